// File: rtl/pyramid_scheduler_if.sv
// Pixel stream path from the frame-buffer reader through the scheduler into downsample.
// The scheduler drives the master side; the frame buffer / downsample pair is the slave.
interface pyramid_scheduler_if;
    logic       pix_valid;
    logic       pix_ready;
    logic       ds_in_valid;
    logic       ds_in_ready;
    logic [3:0] ds_scale;

    modport master (
        input  pix_valid,
        input  ds_in_ready,
        output pix_ready,
        output ds_in_valid,
        output ds_scale
    );

    modport slave (
        output pix_valid,
        output ds_in_ready,
        input  pix_ready,
        input  ds_in_valid,
        input  ds_scale
    );
endinterface

// File: rtl/pyramid_scheduler.sv
// Per-frame HOG pyramid sequencer: replays the frame buffer once per level and gates pixels into downsample.
// Optional macro PYRAMID_SCHED_PERF_EN adds stall_cycles / level_cycles performance outputs.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | one-cycle frame-buffer replay request, pixel counter cleared
// STREAM | valid/ready pass-through, counting transfers
// DRAIN  | full level delivered, waiting for hog_done
// NEXT   | advance level or finish the frame
module pyramid_scheduler #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int NUM_LEVELS = 4,
    parameter int SCALE0     = 9,
    parameter int SCALE_STEP = 2,
    parameter int SCALE_MIN  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       fb_rd_start,
    input  logic       hog_done,
    output logic       busy,
    output logic       frame_done,
    output logic [3:0] level,
    pyramid_scheduler_if.master px
`ifdef PYRAMID_SCHED_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] level_cycles
`endif
);

    localparam int PIX_TOTAL = IMG_W * IMG_H;
    localparam int CNT_W     = (PIX_TOTAL > 1) ? $clog2(PIX_TOTAL) : 1;

    localparam logic [CNT_W-1:0] PIX_LAST   = CNT_W'(PIX_TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       LAST_LEVEL = 4'(NUM_LEVELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        STREAM,
        DRAIN,
        NEXT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] pix_cnt;
    logic             xfer;
    logic             level_last;

    // Signed int arithmetic so large levels saturate at SCALE_MIN instead of wrapping.
    function automatic logic [3:0] scale_for(input logic [3:0] lvl);
        int s;
        s = SCALE0 - int'(lvl) * SCALE_STEP;
        if (s < SCALE_MIN) begin
            s = SCALE_MIN;
        end
        return 4'(s);
    endfunction

    assign level_last = (level == LAST_LEVEL);

    always_comb begin
        state_next     = state;
        fb_rd_start    = 1'b0;
        frame_done     = 1'b0;
        xfer           = 1'b0;
        px.pix_ready   = 1'b0;
        px.ds_in_valid = 1'b0;
        busy           = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                fb_rd_start = 1'b1;
                state_next  = STREAM;
            end
            STREAM: begin
                px.ds_in_valid = px.pix_valid;
                px.pix_ready   = px.ds_in_ready;
                xfer           = px.pix_valid & px.ds_in_ready;
                if (xfer && (pix_cnt == PIX_LAST)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (hog_done) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (level_last) begin
                    frame_done = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Level and scale move together so ds_scale is stable across ISSUE/STREAM/DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt     <= '0;
            level       <= 4'd0;
            px.ds_scale <= 4'(SCALE0);
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        level       <= 4'd0;
                        px.ds_scale <= scale_for(4'd0);
                    end
                end
                ISSUE: begin
                    pix_cnt <= '0;
                end
                STREAM: begin
                    if (xfer) begin
                        pix_cnt <= pix_cnt + CNT_ONE;
                    end
                end
                NEXT: begin
                    if (!level_last) begin
                        level       <= level + 4'd1;
                        px.ds_scale <= scale_for(level + 4'd1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PYRAMID_SCHED_PERF_EN
    logic [31:0] lvl_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            level_cycles <= '0;
            lvl_cnt      <= '0;
        end else begin
            if (state == IDLE && start) begin
                stall_cycles <= '0;
            end else if (state == STREAM && px.pix_valid && !px.ds_in_ready
                         && stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end

            if (state == ISSUE) begin
                lvl_cnt <= '0;
            end else if ((state == STREAM || state == DRAIN) && lvl_cnt != 32'hFFFF_FFFF) begin
                lvl_cnt <= lvl_cnt + 32'd1;
            end

            if (state == NEXT) begin
                level_cycles <= lvl_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pyramid_scheduler.sv
// Directed bench for pyramid_scheduler: 4x2 frame, 3-level instance for sequencing and a 6-level
// instance for scale saturation.
`timescale 1ns/1ps
module tb_pyramid_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start_a, hog_a, fb_a, busy_a, fd_a;
    logic [3:0] level_a;
    pyramid_scheduler_if if_a();

    logic       start_b, hog_b, fb_b, busy_b, fd_b;
    logic [3:0] level_b;
    pyramid_scheduler_if if_b();

`ifdef PYRAMID_SCHED_PERF_EN
    logic [31:0] stall_a, lvlc_a, stall_b, lvlc_b;
`endif

    pyramid_scheduler #(
        .IMG_W(4), .IMG_H(2), .NUM_LEVELS(3),
        .SCALE0(9), .SCALE_STEP(2), .SCALE_MIN(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .fb_rd_start(fb_a), .hog_done(hog_a),
        .busy(busy_a), .frame_done(fd_a), .level(level_a), .px(if_a)
`ifdef PYRAMID_SCHED_PERF_EN
        , .stall_cycles(stall_a), .level_cycles(lvlc_a)
`endif
    );

    pyramid_scheduler #(
        .IMG_W(4), .IMG_H(2), .NUM_LEVELS(6),
        .SCALE0(9), .SCALE_STEP(2), .SCALE_MIN(1)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .fb_rd_start(fb_b), .hog_done(hog_b),
        .busy(busy_b), .frame_done(fd_b), .level(level_b), .px(if_b)
`ifdef PYRAMID_SCHED_PERF_EN
        , .stall_cycles(stall_b), .level_cycles(lvlc_b)
`endif
    );

    int checks = 0;
    int passed = 0;
    int scale_tab [6] = '{9, 7, 5, 3, 1, 1};

    int xfer_a = 0;
    int fb_cnt_a = 0;
    int fd_cnt_a = 0;
    always @(negedge clk) begin
        if (if_a.ds_in_valid && if_a.ds_in_ready) xfer_a++;
        if (fb_a) fb_cnt_a++;
        if (fd_a) fd_cnt_a++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered while dut_a is in ISSUE (sampled); leaves it in ISSUE of the next level or IDLE.
    task automatic run_level(input int lvl, input bit bp, input bit last, input bit inject);
        int x0, nx, cyc, mir_err;
        checks++; if (fb_a !== 1'b1) $display("FAIL issue_fb lvl%0d: got %b want 1", lvl, fb_a); else passed++;
        checks++; if (level_a !== 4'(lvl)) $display("FAIL level lvl%0d: got %0d want %0d", lvl, level_a, lvl); else passed++;
        checks++; if (if_a.ds_scale !== 4'(scale_tab[lvl])) $display("FAIL ds_scale lvl%0d: got %0d want %0d", lvl, if_a.ds_scale, scale_tab[lvl]); else passed++;
        x0 = xfer_a; nx = 0; cyc = 0; mir_err = 0;
        while (nx < 8 && cyc < 40) begin
            tick();
            if_a.ds_in_ready = bp ? (cyc % 2 == 0) : 1'b1;
            start_a = inject && (cyc == 2);
            hog_a   = inject && (cyc == 2);
            #1;
            if (if_a.pix_ready !== if_a.ds_in_ready || if_a.ds_in_valid !== if_a.pix_valid) mir_err++;
            if (if_a.ds_in_valid && if_a.ds_in_ready) nx++;
            cyc++;
        end
        start_a = 1'b0; hog_a = 1'b0; if_a.ds_in_ready = 1'b1;
        checks++; if (nx !== 8) $display("FAIL stream_timeout lvl%0d: got %0d transfers want 8", lvl, nx); else passed++;
        checks++; if (mir_err !== 0) $display("FAIL passthrough lvl%0d: got %0d bad cycles want 0", lvl, mir_err); else passed++;
        tick(); #1;
        checks++; if (if_a.pix_ready !== 1'b0 || if_a.ds_in_valid !== 1'b0)
            $display("FAIL drain_gate lvl%0d: got ready=%b valid=%b want 0 0", lvl, if_a.pix_ready, if_a.ds_in_valid); else passed++;
        tick(); tick(); #1;
        checks++; if (level_a !== 4'(lvl) || busy_a !== 1'b1) $display("FAIL drain_hold lvl%0d: got level=%0d busy=%b want %0d 1", lvl, level_a, busy_a, lvl); else passed++;
        tick();
        hog_a = 1'b1;
        tick();
        hog_a = 1'b0;
        #1;
        checks++; if (xfer_a - x0 !== 8) $display("FAIL xfer_count lvl%0d: got %0d want 8", lvl, xfer_a - x0); else passed++;
        if (last) begin
            checks++; if (fd_a !== 1'b1) $display("FAIL frame_done: got %b want 1", fd_a); else passed++;
            tick(); #1;
            checks++; if (busy_a !== 1'b0 || fd_a !== 1'b0) $display("FAIL idle_after: got busy=%b fd=%b want 0 0", busy_a, fd_a); else passed++;
        end else begin
            checks++; if (fd_a !== 1'b0 || fb_a !== 1'b0) $display("FAIL next_pulses lvl%0d: got fd=%b fb=%b want 0 0", lvl, fd_a, fb_a); else passed++;
            tick(); #1;
        end
    endtask

    task automatic start_frame_a();
        if_a.pix_valid = 1'b1; if_a.ds_in_ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_a = 0; hog_a = 0; start_b = 0; hog_b = 0;
        if_a.pix_valid = 1'b1; if_a.ds_in_ready = 1'b1;
        if_b.pix_valid = 1'b0; if_b.ds_in_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || fb_a !== 1'b0 || fd_a !== 1'b0)
            $display("FAIL reset_ctrl: got busy=%b fb=%b fd=%b want 0 0 0", busy_a, fb_a, fd_a); else passed++;
        checks++; if (level_a !== 4'd0 || if_a.ds_scale !== 4'd9)
            $display("FAIL reset_level: got level=%0d scale=%0d want 0 9", level_a, if_a.ds_scale); else passed++;
        checks++; if (if_a.pix_ready !== 1'b0 || if_a.ds_in_valid !== 1'b0)
            $display("FAIL reset_stream: got ready=%b valid=%b want 0 0", if_a.pix_ready, if_a.ds_in_valid); else passed++;
        hog_a = 1'b1;
        tick();
        hog_a = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) $display("FAIL idle_hog_ignored: got busy=%b want 0", busy_a); else passed++;
    endtask

    task automatic test_basic_frame();
        int fb0, fd0;
        fb0 = fb_cnt_a; fd0 = fd_cnt_a;
        start_frame_a();
        run_level(0, 1'b0, 1'b0, 1'b0);
`ifdef PYRAMID_SCHED_PERF_EN
        checks++; if (lvlc_a !== 32'd12) $display("FAIL level_cycles_basic: got %0d want 12", lvlc_a); else passed++;
`endif
        run_level(1, 1'b0, 1'b0, 1'b0);
        run_level(2, 1'b0, 1'b1, 1'b0);
        checks++; if (fb_cnt_a - fb0 !== 3) $display("FAIL fb_pulses: got %0d want 3", fb_cnt_a - fb0); else passed++;
        checks++; if (fd_cnt_a - fd0 !== 1) $display("FAIL fd_pulses: got %0d want 1", fd_cnt_a - fd0); else passed++;
    endtask

    task automatic test_backpressure();
        start_frame_a();
        run_level(0, 1'b1, 1'b0, 1'b0);
`ifdef PYRAMID_SCHED_PERF_EN
        checks++; if (stall_a !== 32'd7) $display("FAIL stall_cycles: got %0d want 7", stall_a); else passed++;
        checks++; if (lvlc_a !== 32'd19) $display("FAIL level_cycles_bp: got %0d want 19", lvlc_a); else passed++;
`endif
        run_level(1, 1'b1, 1'b0, 1'b0);
        run_level(2, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        int fb0, fd0;
        fb0 = fb_cnt_a; fd0 = fd_cnt_a;
        start_frame_a();
        run_level(0, 1'b0, 1'b0, 1'b1);
        run_level(1, 1'b0, 1'b0, 1'b1);
        run_level(2, 1'b0, 1'b1, 1'b0);
        checks++; if (fb_cnt_a - fb0 !== 3 || fd_cnt_a - fd0 !== 1)
            $display("FAIL ignored_pulses: got fb=%0d fd=%0d want 3 1", fb_cnt_a - fb0, fd_cnt_a - fd0); else passed++;
`ifdef PYRAMID_SCHED_PERF_EN
        checks++; if (stall_a !== 32'd0) $display("FAIL stall_cleared: got %0d want 0", stall_a); else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        int fb0, fd0;
        start_frame_a();
        run_level(0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        fb0 = fb_cnt_a; fd0 = fd_cnt_a;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || level_a !== 4'd0 || if_a.ds_scale !== 4'd9)
            $display("FAIL mid_reset_state: got busy=%b level=%0d scale=%0d want 0 0 9", busy_a, level_a, if_a.ds_scale); else passed++;
        checks++; if (if_a.pix_ready !== 1'b0 || if_a.ds_in_valid !== 1'b0 || fb_a !== 1'b0 || fd_a !== 1'b0)
            $display("FAIL mid_reset_outputs: got ready=%b valid=%b fb=%b fd=%b want 0 0 0 0",
                     if_a.pix_ready, if_a.ds_in_valid, fb_a, fd_a); else passed++;
        tick(); #1;
        checks++; if (fb_cnt_a - fb0 !== 0 || fd_cnt_a - fd0 !== 0)
            $display("FAIL mid_reset_pulses: got fb=%0d fd=%0d want 0 0", fb_cnt_a - fb0, fd_cnt_a - fd0); else passed++;
        test_basic_frame();
    endtask

    task automatic test_saturation();
        int budget;
        if_b.pix_valid = 1'b1; if_b.ds_in_ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        #1;
        for (int l = 0; l < 6; l++) begin
            budget = 0;
            while (fb_b !== 1'b1 && budget < 20) begin
                tick(); #1;
                budget++;
            end
            checks++; if (fb_b !== 1'b1) $display("FAIL sat_issue_timeout lvl%0d: got fb=%b want 1", l, fb_b); else passed++;
            checks++; if (if_b.ds_scale !== 4'(scale_tab[l]))
                $display("FAIL sat_scale lvl%0d: got %0d want %0d", l, if_b.ds_scale, scale_tab[l]); else passed++;
            repeat (12) tick();
            hog_b = 1'b1;
            tick();
            hog_b = 1'b0;
            #1;
        end
        checks++; if (fd_b !== 1'b1) $display("FAIL sat_frame_done: got %b want 1", fd_b); else passed++;
        checks++; if (level_b !== 4'd5) $display("FAIL sat_last_level: got %0d want 5", level_b); else passed++;
        if_b.pix_valid = 1'b0; if_b.ds_in_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_ignored_inputs();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pyramid_scheduler.md
Name: pyramid_scheduler

Overview:
- Sequences the multi-scale HOG image pyramid for each frame.
- For each pyramid level it:
  - requests a frame-buffer replay;
  - configures the downsampler scale;
  - gates the pixel stream into the downsampler through a valid/ready pass-through;
  - waits for the HOG pipeline to report the level finished.
- Sits between the frame-buffer reader and downsample; owns the only path into downsample.

Parameters:
- IMG_W, 640, pixels per line of the source frame.
- IMG_H, 480, lines per source frame.
- NUM_LEVELS, 4, pyramid levels per frame (1..16).
- SCALE0, 9, downsample scale code for level 0.
- SCALE_STEP, 2, scale code decrement per level.
- SCALE_MIN, 1, lower saturation bound of scale code.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse: begin pyramid for a new frame.
- fb_rd_start  out  1  one-cycle pulse: frame buffer restarts readout from pixel 0.
- pix_valid  in  1  frame-buffer pixel valid.
- pix_ready  out  1  ready back to frame buffer.
- ds_in_valid  out  1  valid into downsample.
- ds_in_ready  in  1  downsample in_ready.
- ds_scale  out  4  scale code driven to downsample.
- level  out  4  current pyramid level index.
- hog_done  in  1  pulse: HOG pipeline finished current level.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after last level completes.

Behaviour:
- Interface:
  - Single clock clk.
  - rst synchronous, active-high; all state is updated only on the rising edge of clk.
- Reset values:
  - Outputs: fb_rd_start=0, pix_ready=0, ds_in_valid=0, busy=0, frame_done=0, level=0, ds_scale=SCALE0.
  - Internal: pixel counter=0, state=IDLE.
- FSM states: IDLE, ISSUE, STREAM, DRAIN, NEXT.
- IDLE:
  - start=1 -> ISSUE, level<=0.
  - Any other input is ignored.
- ISSUE:
  - Exactly one cycle; fb_rd_start=1.
  - Pixel counter cleared.
  - -> STREAM.
- STREAM (combinational pass-through):
  - ds_in_valid = pix_valid.
  - pix_ready = ds_in_ready.
  - Outside STREAM both outputs are 0 regardless of inputs.
- Transfers and counting:
  - A transfer is pix_valid & ds_in_ready in STREAM; the counter increments by 1 per transfer.
  - Counter width is clog2(IMG_W*IMG_H).
  - On the transfer where counter == IMG_W*IMG_H-1 -> DRAIN; that transfer is still passed.
  - pix_valid held high across the boundary does not produce an extra transfer, because pix_ready is 0 from DRAIN onward.
- DRAIN:
  - Waits for hog_done.
  - hog_done -> NEXT.
  - hog_done in any other state is ignored.
- NEXT:
  - One cycle.
  - If level == NUM_LEVELS-1: -> IDLE and frame_done=1 for that cycle.
  - Else: level<=level+1, -> ISSUE.
- ds_scale = max(SCALE0 - level*SCALE_STEP, SCALE_MIN):
  - Computed in signed arithmetic of sufficient width; no wrap.
  - Registered; it updates in the same cycle level updates, so it is stable for the whole ISSUE/STREAM/DRAIN window.
- start while busy=1 is ignored; it is not queued.
- Latency, level 0:
  - start high at edge N -> ISSUE (fb_rd_start high) in cycle N+1.
  - STREAM from cycle N+2.
- Latency, level to level: hog_done sampled in DRAIN -> NEXT, then ISSUE 2 cycles after hog_done.
- rst mid-operation:
  - Returns to IDLE within one cycle; counter and level cleared.
  - No fb_rd_start or frame_done pulse is generated by the reset.

Optional Feature:
- Macro: PYRAMID_SCHED_PERF_EN.
- With macro defined, adds two outputs:
  - stall_cycles (32 bits): counts STREAM cycles with pix_valid=1 and ds_in_ready=0. Saturates at 2^32-1. Cleared on rst and when start is accepted.
  - level_cycles (32 bits): cycles spent in STREAM+DRAIN for the most recently completed level, captured in NEXT.
- Without macro: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame, IMG_W=4, IMG_H=2, NUM_LEVELS=3, pix_valid=ds_in_ready=1, hog_done pulsed 3 cycles after entering DRAIN:
  - fb_rd_start pulses 3 times.
  - Exactly 8 ds_in_valid&ds_in_ready transfers per level.
  - level sequence 0,1,2; ds_scale sequence 9,7,5.
  - One frame_done pulse.
- Backpressure:
  - ds_in_ready toggles 1,0,1,0 and pix_valid=1.
  - pix_ready mirrors ds_in_ready each cycle; still 8 transfers per level.
  - With PYRAMID_SCHED_PERF_EN, stall_cycles=7 after level 0.
- Saturation, NUM_LEVELS=6, SCALE0=9, SCALE_STEP=2: ds_scale sequence 9,7,5,3,1,1.
- Ignored inputs:
  - start pulsed during STREAM and hog_done pulsed during STREAM: no effect.
  - Level advances only on hog_done in DRAIN.
- Boundary: pix_valid held high after the 8th transfer -> pix_ready=0 and ds_in_valid=0 in DRAIN; no 9th transfer.
- Reset mid-operation:
  - rst asserted 1 cycle in STREAM of level 1 -> next cycle busy=0, level=0, ds_scale=9, outputs idle.
  - A subsequent start runs a full clean frame.
